ddd_prog_sched: RTL and testbench
=================================

Name: ddd_prog_sched

Overview:
- Schedules programming cycles for the 3D3444 delay-chip programmer (start/busy/verify_ok interface).
- Arbitrates between two requesters: a VME write request and a TTC/resync request. Issues one start handshake per grant.
- Checks the verify result, automatically retries on a readback mismatch, and guards every handshake phase with a timeout.
- Sits between the VME register block and the delay-chip programmer, and reports status back to VME.

Parameters:
- MAX_RETRY, 3, number of additional attempts after a failed verify (0 means no retry).
- TMO_W, 10, width of the timeout counter; a timeout fires after 2**TMO_W-1 cycles in one phase.
- SETTLE, 2, number of cycles after busy falls before verify_ok is sampled (1..7).

Ports:
- clock  in  1  programmer clock; same clock as the delay-chip programmer.
- global_reset  in  1  asynchronous, active-high reset.
- req_vme  in  1  VME program request; single-cycle pulse.
- req_ttc  in  1  TTC/resync program request; single-cycle pulse.
- ddd_busy  in  1  programmer busy. High while power-up has not completed and while a cycle runs.
- ddd_verify_ok  in  1  programmer readback compare result.
- ddd_start  out  1  start command to the programmer; level signal.
- sched_busy  out  1  scheduler is not in IDLE.
- done  out  1  one-cycle pulse when a job ends, pass or fail.
- pass  out  1  sticky result of the last job; 1 means verify passed.
- timeout  out  1  sticky flag; the last job ended on a timeout.
- retries  out  2  number of retries used by the last job.
- src_ttc  out  1  source of the last job; 1 means TTC, 0 means VME.

Behaviour:
- Reset values: all outputs 0, state IDLE, both pending flags 0, counters 0.
- Request capture:
  - Each req_* pulse sets its own pending flag; the flag is held until that job is granted.
  - Repeated pulses while a flag is already pending merge into one job.
  - A pulse arriving during an active job is captured, not lost.
- Arbitration happens in IDLE only:
  - VME has fixed priority when both flags are pending in the same cycle.
  - On a grant: clear the granted pending flag, latch src_ttc, clear retries, pass and timeout.
- States and transitions:
  - IDLE: if any flag is pending, go to WAIT_FREE.
  - WAIT_FREE: wait for ddd_busy=0, i.e. the programmer has finished power-up or autostart. Then go to START.
  - START: assert ddd_start. When ddd_busy=1 is seen, deassert ddd_start on the next edge and go to RUN.
  - RUN: wait for ddd_busy=0, then go to SETTLE.
  - SETTLE: count SETTLE cycles, then sample ddd_verify_ok.
    - If it is 1: set pass=1 and go to FINISH.
    - If it is 0 and retries<MAX_RETRY: increment retries and go to START.
    - Otherwise: set pass=0 and go to FINISH.
  - FINISH: pulse done for one cycle, then return to IDLE.
- ddd_start rules:
  - Registered output; high only in START.
  - Must drop within 1 cycle of seeing busy, so the programmer's unstart state exits.
  - Never reasserted without passing through RUN.
- Timeout:
  - The counter clears on every state entry and counts in WAIT_FREE, START and RUN.
  - On reaching all-ones: deassert ddd_start, set timeout=1 and pass=0, then go to FINISH. No retry is attempted after a timeout.
- Boundaries:
  - A busy glitch shorter than 1 cycle in START is treated as seen.
  - busy already high on START entry is accepted immediately. This is safe only because WAIT_FREE guaranteed busy was low first.
  - Retry counter saturates at MAX_RETRY.
  - Asynchronous reset mid-job returns to IDLE with ddd_start=0 and drops pending requests. A programmer cycle already in flight runs to completion unattended.
- Width rules: retries is 2 bits, which requires MAX_RETRY≤3. Include a static check on this parameter.

Decomposition:
- Package ddd_sched_pkg holds:
  - the state encoding constants (IDLE, WAIT_FREE, START, RUN, SETTLE, FINISH), 3-bit;
  - the source encoding.
- The state register uses the safe-implementation attribute, with an illegal-state recovery to IDLE.
- One natural sub-module: ddd_req_latch, containing the two pending flags and the priority grant logic.

Test Plan:
- Single VME pulse; model busy high 4 cycles after start and low 70 cycles later; verify_ok=1:
  - ddd_start high until the busy edge;
  - done pulses once;
  - pass=1, retries=0, src_ttc=0.
- req_vme and req_ttc in the same cycle:
  - VME job runs first (src_ttc=0 at the first done);
  - TTC job follows automatically (src_ttc=1 at the second done);
  - exactly two start handshakes.
- verify_ok=0 on the first two attempts and 1 on the third:
  - three start handshakes;
  - retries=2, pass=1.
- verify_ok always 0 with MAX_RETRY=3:
  - four handshakes;
  - pass=0, retries=3, timeout=0.
- Busy never rises after start:
  - after 1023 cycles ddd_start drops;
  - timeout=1, pass=0, done pulses.
- Busy held high from reset (programmer still powering up) with req_vme:
  - scheduler stays in WAIT_FREE with ddd_start=0.
- global_reset asserted during RUN:
  - all outputs go to 0 asynchronously, including ddd_start;
  - scheduler is idle after release.

Source files
------------

// File: rtl/ddd_sched_pkg.sv
// Shared encodings for the 3D3444 delay-chip programming scheduler.
package ddd_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_FREE = 3'd1,
    ST_START     = 3'd2,
    ST_RUN       = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  typedef enum logic {
    SRC_VME = 1'b0,
    SRC_TTC = 1'b1
  } src_t;

  localparam int RETRY_W      = 2;
  localparam int SETTLE_CNT_W = 3;

endpackage

// File: rtl/ddd_req_latch.sv
// Pending-request flags for the VME and TTC requesters with fixed-priority grant.
module ddd_req_latch
  import ddd_sched_pkg::*;
(
  input  logic clock,
  input  logic global_reset,
  input  logic req_vme,
  input  logic req_ttc,
  input  logic arb_en,
  output logic grant,
  output src_t grant_src
);

  logic pend_vme_q;
  logic pend_ttc_q;
  logic clr_vme;
  logic clr_ttc;

  // VME wins whenever both are pending.
  assign grant     = arb_en & (pend_vme_q | pend_ttc_q);
  assign grant_src = pend_vme_q ? SRC_VME : SRC_TTC;
  assign clr_vme   = grant & (grant_src == SRC_VME);
  assign clr_ttc   = grant & (grant_src == SRC_TTC);

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      pend_vme_q <= 1'b0;
      pend_ttc_q <= 1'b0;
    end else begin
      // Set dominates clear: a pulse coinciding with its own grant queues a new job.
      pend_vme_q <= req_vme | (pend_vme_q & ~clr_vme);
      pend_ttc_q <= req_ttc | (pend_ttc_q & ~clr_ttc);
    end
  end

endmodule

// File: rtl/ddd_prog_sched.sv
// Programming-cycle scheduler: arbitration, start handshake, verify with retry,
// and per-phase timeout for the 3D3444 delay-chip programmer.
module ddd_prog_sched
  import ddd_sched_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int TMO_W     = 10,
  parameter int SETTLE    = 2
) (
  input  logic       clock,
  input  logic       global_reset,
  input  logic       req_vme,
  input  logic       req_ttc,
  input  logic       ddd_busy,
  input  logic       ddd_verify_ok,
  output logic       ddd_start,
  output logic       sched_busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [1:0] retries,
  output logic       src_ttc
);

  if (MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_bad_max_retry
    $error("ddd_prog_sched: MAX_RETRY must be in 0..3 to fit the 2-bit retries port");
  end
  if (SETTLE < 1 || SETTLE > 7) begin : g_bad_settle
    $error("ddd_prog_sched: SETTLE must be in 1..7");
  end

  (* syn_encoding = "safe" *) state_t state_q;
  state_t                    state_d;
  logic [TMO_W-1:0]          tmo_q;
  logic [SETTLE_CNT_W-1:0]   settle_q;
  logic [RETRY_W-1:0]        retries_q;
  logic                      grant;
  src_t                      grant_src;
  logic                      tmo_hit;
  logic                      settle_done;
  logic                      retry_ok;
  logic                      set_pass;
  logic                      set_tmo;
  logic                      inc_retry;

  ddd_req_latch u_req_latch (
    .clock        (clock),
    .global_reset (global_reset),
    .req_vme      (req_vme),
    .req_ttc      (req_ttc),
    .arb_en       (state_q == ST_IDLE),
    .grant        (grant),
    .grant_src    (grant_src)
  );

  assign tmo_hit     = &tmo_q;
  assign settle_done = (settle_q == SETTLE_CNT_W'(SETTLE - 1));
  assign retry_ok    = (int'(retries_q) < MAX_RETRY);
  assign sched_busy  = (state_q != ST_IDLE);
  assign retries     = retries_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    set_pass  = 1'b0;
    set_tmo   = 1'b0;
    inc_retry = 1'b0;
    case (state_q)
      ST_IDLE:
        if (grant) state_d = ST_WAIT_FREE;
      ST_WAIT_FREE:
        if (tmo_hit) begin
          set_tmo = 1'b1;
          state_d = ST_FINISH;
        end else if (!ddd_busy) begin
          state_d = ST_START;
        end
      ST_START:
        // Busy already high on entry counts as the acknowledge; WAIT_FREE saw it low.
        if (tmo_hit) begin
          set_tmo = 1'b1;
          state_d = ST_FINISH;
        end else if (ddd_busy) begin
          state_d = ST_RUN;
        end
      ST_RUN:
        if (tmo_hit) begin
          set_tmo = 1'b1;
          state_d = ST_FINISH;
        end else if (!ddd_busy) begin
          state_d = ST_SETTLE;
        end
      ST_SETTLE:
        if (settle_done) begin
          if (ddd_verify_ok) begin
            set_pass = 1'b1;
            state_d  = ST_FINISH;
          end else if (retry_ok) begin
            inc_retry = 1'b1;
            state_d   = ST_START;
          end else begin
            state_d = ST_FINISH;
          end
        end
      ST_FINISH:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      settle_q  <= '0;
      retries_q <= '0;
      ddd_start <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      src_ttc   <= 1'b0;
    end else begin
      state_q <= state_d;

      // Both counters restart on any state entry, including SETTLE -> START retries.
      if (state_d != state_q)
        tmo_q <= '0;
      else if (state_q inside {ST_WAIT_FREE, ST_START, ST_RUN})
        tmo_q <= tmo_q + 1'b1;

      if (state_d != state_q)
        settle_q <= '0;
      else if (state_q == ST_SETTLE)
        settle_q <= settle_q + 1'b1;

      // Decoded from next state so the outputs are registered yet track the state exactly.
      ddd_start <= (state_d == ST_START);
      done      <= (state_d == ST_FINISH);

      if (grant) begin
        src_ttc   <= (grant_src == SRC_TTC);
        retries_q <= '0;
        pass      <= 1'b0;
        timeout   <= 1'b0;
      end
      if (inc_retry) retries_q <= retries_q + 1'b1;
      if (set_pass)  pass      <= 1'b1;
      if (set_tmo)   timeout   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddd_prog_sched.sv
// Scoreboard bench for ddd_prog_sched with a behavioural delay-chip programmer model.
module tb_ddd_prog_sched;

  logic       clock = 1'b0;
  logic       global_reset;
  logic       req_vme;
  logic       req_ttc;
  logic       ddd_busy;
  logic       ddd_verify_ok;
  logic       ddd_start;
  logic       sched_busy;
  logic       done;
  logic       pass;
  logic       timeout;
  logic [1:0] retries;
  logic       src_ttc;

  always #5 clock = ~clock;

  ddd_prog_sched #(.MAX_RETRY(3), .TMO_W(10), .SETTLE(2)) dut (
    .clock         (clock),
    .global_reset  (global_reset),
    .req_vme       (req_vme),
    .req_ttc       (req_ttc),
    .ddd_busy      (ddd_busy),
    .ddd_verify_ok (ddd_verify_ok),
    .ddd_start     (ddd_start),
    .sched_busy    (sched_busy),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .retries       (retries),
    .src_ttc       (src_ttc)
  );

  typedef struct packed {
    logic       pass;
    logic       timeout;
    logic [1:0] retries;
    logic       src_ttc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   jobs_done  = 0;
  int   handshakes = 0;

  // Programmer model configuration; vok_seq[i] is the verify result of attempt i.
  logic [3:0] vok_seq    = 4'b1111;
  logic       never_busy = 1'b0;
  logic       force_busy = 1'b0;
  int         cfg_gen    = 0;
  logic       mdl_active = 1'b0;

  // Busy rises 4 cycles after start is seen and stays high for 70 cycles.
  initial begin
    int mdl_cnt;
    int attempt;
    int seen_gen;
    mdl_cnt = 0; attempt = 0; seen_gen = 0;
    ddd_busy = 1'b0;
    ddd_verify_ok = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (cfg_gen != seen_gen) begin
        seen_gen = cfg_gen;
        attempt  = 0;
      end
      if (force_busy) begin
        ddd_busy   = 1'b1;
        mdl_active = 1'b0;
      end else if (!mdl_active) begin
        ddd_busy = 1'b0;
        if (ddd_start && !never_busy) begin
          mdl_active = 1'b1;
          mdl_cnt    = 0;
        end
      end else begin
        mdl_cnt++;
        if (mdl_cnt == 4) begin
          ddd_busy = 1'b1;
        end else if (mdl_cnt == 74) begin
          ddd_busy      = 1'b0;
          ddd_verify_ok = (attempt < 4) ? vok_seq[attempt] : 1'b1;
          attempt++;
          mdl_active = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: pops one expected result per done pulse.
  initial begin
    logic done_prev;
    logic start_prev;
    exp_t got;
    exp_t e;
    done_prev = 1'b0;
    start_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (ddd_start && !start_prev) handshakes++;
      start_prev = ddd_start;
      if (done) begin
        n_checks++;
        if (done_prev) $display("FAIL done_width: done high on consecutive cycles, required a one-cycle pulse");
        else n_pass++;
        if (!done_prev) begin
          jobs_done++;
          got = {pass, timeout, retries, src_ttc};
          n_checks++;
          if (sb_q.size() == 0) begin
            $display("FAIL unexpected_done: got result %b, required no job completion", got);
          end else begin
            e = sb_q.pop_front();
            if (got !== e)
              $display("FAIL job_result: got {pass,timeout,retries,src_ttc}=%b, required %b", got, e);
            else n_pass++;
          end
        end
      end
      done_prev = done;
    end
  end

  task automatic config_model(input logic [3:0] vok, input logic nb, input logic fb);
    vok_seq    = vok;
    never_busy = nb;
    force_busy = fb;
    cfg_gen++;
  endtask

  task automatic pulse(input logic v, input logic t);
    @(negedge clock);
    req_vme = v;
    req_ttc = t;
    @(negedge clock);
    req_vme = 1'b0;
    req_ttc = 1'b0;
  endtask

  task automatic wait_jobs(input int n, input int budget, output bit ok);
    int target;
    int cyc;
    target = jobs_done + n;
    cyc = 0;
    while (jobs_done < target && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    ok = (jobs_done >= target);
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((sched_busy || mdl_active || ddd_busy) && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
    n_checks++;
    if (sched_busy || mdl_active || ddd_busy)
      $display("FAIL idle_wait: got sched_busy=%b busy=%b after %0d cycles, required idle", sched_busy, ddd_busy, cyc);
    else n_pass++;
  endtask

  task automatic test_reset();
    global_reset = 1'b1;
    req_vme = 1'b0;
    req_ttc = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({ddd_start, sched_busy, done, pass, timeout, retries, src_ttc} !== 8'b0)
      $display("FAIL reset_outputs: got %b, required 00000000",
               {ddd_start, sched_busy, done, pass, timeout, retries, src_ttc});
    else n_pass++;
    global_reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single();
    int  h0;
    int  cyc;
    bit  ok;
    config_model(4'b1111, 1'b0, 1'b0);
    h0 = handshakes;
    sb_q.push_back(exp_t'{1'b1, 1'b0, 2'd0, 1'b0});
    pulse(1'b1, 1'b0);
    cyc = 0;
    while (!ddd_busy && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    n_checks++;
    if ({ddd_busy, ddd_start} !== 2'b11)
      $display("FAIL start_until_busy: got busy,start=%b, required 11", {ddd_busy, ddd_start});
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (ddd_start !== 1'b0) $display("FAIL start_drop: got ddd_start=%b, required 0", ddd_start);
    else n_pass++;
    wait_jobs(1, 300, ok);
    n_checks++;
    if (!ok) $display("FAIL single_done: got no done within 300 cycles, required one job");
    else n_pass++;
    n_checks++;
    if (handshakes - h0 !== 1) $display("FAIL single_handshakes: got %0d, required 1", handshakes - h0);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_timeout();
    int hi;
    int cyc;
    int target;
    config_model(4'b1111, 1'b1, 1'b0);
    sb_q.push_back(exp_t'{1'b0, 1'b1, 2'd0, 1'b0});
    target = jobs_done + 1;
    pulse(1'b1, 1'b0);
    hi = 0;
    cyc = 0;
    while (jobs_done < target && cyc < 2000) begin
      @(negedge clock);
      if (ddd_start) hi++;
      cyc++;
    end
    n_checks++;
    if (jobs_done < target) $display("FAIL timeout_done: got no done within 2000 cycles, required one");
    else n_pass++;
    n_checks++;
    if (hi < 1023 || hi > 1024) $display("FAIL timeout_start_len: got ddd_start high %0d cycles, required 1023..1024", hi);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if ({timeout, pass, ddd_start} !== 3'b100)
      $display("FAIL timeout_sticky: got timeout,pass,start=%b, required 100", {timeout, pass, ddd_start});
    else n_pass++;
    config_model(4'b1111, 1'b0, 1'b0);
    wait_idle();
  endtask

  task automatic test_retry();
    int h0;
    bit ok;
    config_model(4'b0100, 1'b0, 1'b0);
    h0 = handshakes;
    sb_q.push_back(exp_t'{1'b1, 1'b0, 2'd2, 1'b0});
    pulse(1'b1, 1'b0);
    wait_jobs(1, 600, ok);
    n_checks++;
    if (!ok) $display("FAIL retry_done: got no done within 600 cycles, required one");
    else n_pass++;
    n_checks++;
    if (handshakes - h0 !== 3) $display("FAIL retry_handshakes: got %0d, required 3", handshakes - h0);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int h0;
    bit ok;
    config_model(4'b1111, 1'b0, 1'b0);
    h0 = handshakes;
    sb_q.push_back(exp_t'{1'b1, 1'b0, 2'd0, 1'b0});
    sb_q.push_back(exp_t'{1'b1, 1'b0, 2'd0, 1'b1});
    pulse(1'b1, 1'b1);
    pulse(1'b0, 1'b1);
    wait_jobs(2, 800, ok);
    n_checks++;
    if (!ok) $display("FAIL b2b_done: got %0d of 2 jobs, required 2", sb_q.size() == 0 ? 2 : 2 - sb_q.size());
    else n_pass++;
    n_checks++;
    if (handshakes - h0 !== 2) $display("FAIL b2b_handshakes: got %0d, required 2", handshakes - h0);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_all_fail();
    int h0;
    bit ok;
    config_model(4'b0000, 1'b0, 1'b0);
    h0 = handshakes;
    sb_q.push_back(exp_t'{1'b0, 1'b0, 2'd3, 1'b0});
    pulse(1'b1, 1'b0);
    wait_jobs(1, 800, ok);
    n_checks++;
    if (!ok) $display("FAIL allfail_done: got no done within 800 cycles, required one");
    else n_pass++;
    n_checks++;
    if (handshakes - h0 !== 4) $display("FAIL allfail_handshakes: got %0d, required 4", handshakes - h0);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_powerup();
    int h0;
    bit ok;
    config_model(4'b1111, 1'b0, 1'b1);
    global_reset = 1'b1;
    repeat (2) @(negedge clock);
    global_reset = 1'b0;
    h0 = handshakes;
    sb_q.push_back(exp_t'{1'b1, 1'b0, 2'd0, 1'b0});
    pulse(1'b1, 1'b0);
    repeat (40) @(negedge clock);
    n_checks++;
    if ({sched_busy, ddd_start} !== 2'b10 || handshakes != h0)
      $display("FAIL powerup_wait: got sched_busy,start=%b handshakes=%0d, required 10 and 0",
               {sched_busy, ddd_start}, handshakes - h0);
    else n_pass++;
    config_model(4'b1111, 1'b0, 1'b0);
    wait_jobs(1, 300, ok);
    n_checks++;
    if (!ok) $display("FAIL powerup_done: got no done after busy release, required one");
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_reset_mid_job();
    int cyc;
    int bad;
    config_model(4'b1111, 1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    cyc = 0;
    while (!ddd_busy && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    repeat (5) @(negedge clock);
    pulse(1'b1, 1'b0);
    n_checks++;
    if ({sched_busy, src_ttc} !== 2'b11)
      $display("FAIL run_before_reset: got sched_busy,src_ttc=%b, required 11", {sched_busy, src_ttc});
    else n_pass++;
    #2;
    global_reset = 1'b1;
    #1;
    n_checks++;
    if ({ddd_start, sched_busy, done, pass, timeout, retries, src_ttc} !== 8'b0)
      $display("FAIL async_reset: got %b, required 00000000",
               {ddd_start, sched_busy, done, pass, timeout, retries, src_ttc});
    else n_pass++;
    @(negedge clock);
    global_reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clock);
      if (sched_busy || ddd_start) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL idle_after_reset: got %0d active cycles, required 0", bad);
    else n_pass++;
    wait_idle();
  endtask

  initial begin
    global_reset = 1'b1;
    req_vme = 1'b0;
    req_ttc = 1'b0;
    test_reset();
    test_single();
    test_timeout();
    test_retry();
    test_back_to_back();
    test_all_fail();
    test_powerup();
    test_reset_mid_job();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_empty: got %0d outstanding jobs, required 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
